// File: rtl/sat_up_itl_pkg.sv
// Shared definitions for the SAT_UP ping-pong block interleaver.
//   - link geometry table (link id -> rows, cols, frame length - 1)
//   - memory sizing constants
//   - bank-state and write-FSM encodings, per-bank frame descriptor
package sat_up_itl_pkg;

  localparam int ITL_MAX_ROWS = 16;
  localparam int ITL_MAX_COLS = 16;
  localparam int MAX_N        = ITL_MAX_ROWS * ITL_MAX_COLS;
  localparam int ADDR_W       = $clog2(2 * MAX_N);
  localparam int DIM_W        = $clog2(ITL_MAX_ROWS + 1);
  localparam int CNT_W        = $clog2(MAX_N);

  typedef enum logic [1:0] {
    BK_EMPTY   = 2'd0,
    BK_FILLING = 2'd1,
    BK_FULL    = 2'd2,
    BK_READING = 2'd3
  } bank_st_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_FILL = 1'b1
  } w_state_e;

  // n_m1 holds N-1 so the table needs no multiplier and fits CNT_W bits.
  typedef struct packed {
    logic [DIM_W-1:0] rows;
    logic [DIM_W-1:0] cols;
    logic [CNT_W-1:0] n_m1;
  } geom_t;

  typedef struct packed {
    geom_t g;
    logic  mode;
  } desc_t;

  // rows == 0 marks an unknown link id.
  function automatic geom_t sat_up_itl_geom(input logic [7:0] id);
    geom_t g;
    g = '0;
    case (id)
      8'h00: begin g.rows = DIM_W'(4);  g.cols = DIM_W'(4);  g.n_m1 = CNT_W'(15);  end
      8'h14: begin g.rows = DIM_W'(8);  g.cols = DIM_W'(12); g.n_m1 = CNT_W'(95);  end
      8'h20: begin g.rows = DIM_W'(16); g.cols = DIM_W'(16); g.n_m1 = CNT_W'(255); end
      default: g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sat_up_itl_ram.sv
// Simple dual-port RAM holding both interleaver banks (bank = address MSB).
// Ports:
//   clk            clock
//   we/waddr/wdata write port, written on the rising edge
//   re/raddr       read request, data appears on q one cycle later
//   q              registered read data (holds when re is low)
module sat_up_itl_ram #(
  parameter int DW = 1,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/sat_up_itl_pp.sv
// Ping-pong block interleaver / deinterleaver for the SAT_UP uplink.
// One bank fills while the other drains; geometry and direction are latched
// per frame from link_id / itl_mode on the frame's first sample.
// Ports:
//   clk, n_rst         clock, synchronous active-low reset
//   link_id, itl_mode  frame geometry selector, 1 = interleave 0 = deinterleave
//   din, din_vld       input samples; din_rdy low means samples are dropped
//   request            pop one output sample per cycle
//   dout, dout_vld     output sample, one cycle after a serviced request
//   dout_last          last sample of a frame
// Optional (macro SAT_UP_ITL_ERR_EN): ovf, udf, bad_id registered error pulses.
module sat_up_itl_pp
  import sat_up_itl_pkg::*;
#(
  parameter int DW       = 1,
  parameter int MAX_ROWS = ITL_MAX_ROWS,
  parameter int MAX_COLS = ITL_MAX_COLS,
  parameter int ID_W     = 6
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [ID_W-1:0] link_id,
  input  logic            itl_mode,
  input  logic [DW-1:0]   din,
  input  logic            din_vld,
  output logic            din_rdy,
  input  logic            request,
  output logic [DW-1:0]   dout,
  output logic            dout_vld,
  output logic            dout_last
`ifdef SAT_UP_ITL_ERR_EN
  ,
  output logic            ovf,
  output logic            udf,
  output logic            bad_id
`endif
);

  localparam int LAW = $clog2(MAX_ROWS * MAX_COLS);

  // Next address within a bank. Column-major walks add the row stride and
  // wrap by subtracting N-1 once the row counter reaches the last row.
  function automatic void step_addr(
    input  logic [LAW-1:0]   addr,
    input  logic [DIM_W-1:0] r,
    input  geom_t            g,
    input  logic             by_col,
    output logic [LAW-1:0]   addr_n,
    output logic [DIM_W-1:0] r_n
  );
    if (!by_col) begin
      addr_n = addr + 1'b1;
      r_n    = '0;
    end else if (r == g.rows - 1'b1) begin
      addr_n = addr + LAW'(g.cols) - LAW'(g.n_m1);
      r_n    = '0;
    end else begin
      addr_n = addr + LAW'(g.cols);
      r_n    = r + 1'b1;
    end
  endfunction

  w_state_e         w_state;
  bank_st_e         bank_st [2];
  desc_t            desc    [2];
  logic             w_ptr, rd_ptr;
  logic [LAW-1:0]   w_addr, w_cnt, r_addr, r_cnt;
  logic [DIM_W-1:0] w_r, r_r;
  logic             rd_vld_p1, rd_last_p1;
  logic [DW-1:0]    ram_q;

  geom_t            id_g, cur_g, rd_g;
  logic             cur_mode;
  logic             accept, we, w_last, rd_ok, serviced, r_last;
  logic [LAW-1:0]   w_addr_n, r_addr_n;
  logic [DIM_W-1:0] w_r_n, r_r_n;

  // ---- stage p0: write-side and read-side address/control decode ----
  always_comb begin
    id_g     = sat_up_itl_geom(8'(link_id));
    cur_g    = desc[w_ptr].g;
    cur_mode = desc[w_ptr].mode;
    if (w_state == W_IDLE) begin
      cur_g    = id_g;
      cur_mode = itl_mode;
    end
    din_rdy = (w_state == W_FILL) || (bank_st[w_ptr] == BK_EMPTY);
    accept  = din_vld && din_rdy;
    // Unknown-geometry samples are accepted but never reach memory.
    we      = accept && ((w_state == W_FILL) || (id_g.rows != '0));
    w_last  = (w_cnt == LAW'(cur_g.n_m1));
    // Interleave writes row-major; deinterleave writes column-major.
    step_addr(w_addr, w_r, cur_g, !cur_mode, w_addr_n, w_r_n);

    rd_g     = desc[rd_ptr].g;
    rd_ok    = (bank_st[rd_ptr] == BK_FULL) || (bank_st[rd_ptr] == BK_READING);
    serviced = request && rd_ok;
    r_last   = (r_cnt == LAW'(rd_g.n_m1));
    step_addr(r_addr, r_r, rd_g, desc[rd_ptr].mode, r_addr_n, r_r_n);
  end

  // Descriptors are data: written on a frame's first sample, never reset.
  always_ff @(posedge clk) begin
    if (we && (w_state == W_IDLE)) begin
      desc[w_ptr].g    <= id_g;
      desc[w_ptr].mode <= itl_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      w_state    <= W_IDLE;
      bank_st[0] <= BK_EMPTY;
      bank_st[1] <= BK_EMPTY;
      w_ptr      <= 1'b0;
      rd_ptr     <= 1'b0;
      w_addr     <= '0;
      w_cnt      <= '0;
      w_r        <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_r        <= '0;
      rd_vld_p1  <= 1'b0;
      rd_last_p1 <= 1'b0;
    end else begin
      if (we) begin
        if (w_last) begin
          bank_st[w_ptr] <= BK_FULL;
          w_state        <= W_IDLE;
          w_ptr          <= ~w_ptr;
          w_addr         <= '0;
          w_cnt          <= '0;
          w_r            <= '0;
        end else begin
          bank_st[w_ptr] <= BK_FILLING;
          w_state        <= W_FILL;
          w_addr         <= w_addr_n;
          w_cnt          <= w_cnt + 1'b1;
          w_r            <= w_r_n;
        end
      end
      // The read bank is never the write bank, so both updates can land
      // in the same cycle.
      if (serviced) begin
        if (r_last) begin
          bank_st[rd_ptr] <= BK_EMPTY;
          rd_ptr          <= ~rd_ptr;
          r_addr          <= '0;
          r_cnt           <= '0;
          r_r             <= '0;
        end else begin
          bank_st[rd_ptr] <= BK_READING;
          r_addr          <= r_addr_n;
          r_cnt           <= r_cnt + 1'b1;
          r_r             <= r_r_n;
        end
      end
      rd_vld_p1  <= serviced;
      rd_last_p1 <= serviced && r_last;
    end
  end

  sat_up_itl_ram #(
    .DW (DW),
    .AW (LAW + 1)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({w_ptr, w_addr}),
    .wdata (din),
    .re    (serviced),
    .raddr ({rd_ptr, r_addr}),
    .q     (ram_q)
  );

  // ---- stage p1: registered RAM output ----
  // RAM data is not reset, so gate it to keep dout at 0 when not valid.
  assign dout      = rd_vld_p1 ? ram_q : '0;
  assign dout_vld  = rd_vld_p1;
  assign dout_last = rd_last_p1;

`ifdef SAT_UP_ITL_ERR_EN
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      ovf    <= 1'b0;
      udf    <= 1'b0;
      bad_id <= 1'b0;
    end else begin
      ovf    <= din_vld && !din_rdy;
      udf    <= request && !rd_ok;
      bad_id <= accept && (w_state == W_IDLE) && (id_g.rows == '0);
    end
  end
`endif

endmodule

// File: doc/sat_up_itl_pp.md
# sat_up_itl_pp

Parametrised ping-pong block interleaver/deinterleaver for the SAT_UP uplink chain. It sits between the bit/soft-symbol source and the modulator/decoder. Frames of configurable width and size are written row-major and read column-major (interleave) or the inverse (deinterleave), with the geometry selected by `link_id`. Two memory banks let one frame be written while the previous one is drained by `request` pulses.

## Interface
- DW, 1, sample width in bits (1 = hard bits, >1 = soft values)
- MAX_ROWS, 16, largest row count in the link table
- MAX_COLS, 16, largest column count in the link table
- ID_W, 6, width of `link_id`
- clk  in  1  clock, all logic on rising edge
- n_rst  in  1  reset, synchronous, active-low
- link_id  in  ID_W  frame geometry selector, sampled on the first accepted sample of a frame
- itl_mode  in  1  1 = interleave, 0 = deinterleave; sampled together with `link_id`
- din  in  DW  input sample
- din_vld  in  1  `din` valid
- din_rdy  out  1  a bank is free or currently filling; samples with `din_vld` && !`din_rdy` are dropped
- request  in  1  pop one output sample per cycle while high
- dout  out  DW  output sample
- dout_vld  out  1  `dout` valid
- dout_last  out  1  with `dout_vld`, marks the last sample of a frame

## Operation
- The geometry table lives in the package as a function id→{rows, cols}:
  - 0x00 → 4×4 (N=16)
  - 0x14 → 8×12 (N=96)
  - 0x20 → 16×16 (N=256)
  - every other id → 0×0 (invalid)
- A frame with invalid geometry is rejected: its samples are consumed and discarded, no bank is committed.
- Write FSM, states W_IDLE and W_FILL:
  - W_IDLE→W_FILL on accepted `din_vld`. That first sample is written; geometry and mode are latched into the target bank's descriptor.
  - W_FILL→W_IDLE after the N-th sample. The bank is then marked FULL.
- Each bank has a state EMPTY, FILLING, FULL or READING. Write targets the EMPTY bank; read serves the oldest FULL bank, so frame order is preserved.
- Interleave write address = r·cols + c, with c incrementing fastest. Interleave read runs the same address set with r incrementing fastest.
- Deinterleave swaps the write and read orders.
- Addresses come from incremental counters: add `cols` (stride), wrap at `rows` (subtract rows·cols−1). No multiplier in the read path.
- Read: `request` while a bank is FULL/READING issues one memory read. After the N-th read the bank returns to EMPTY.
- `request` with no readable bank is ignored.

## Timing
- Reset (`n_rst` low at a rising edge), reset values:
  - `dout`=0, `dout_vld`=0, `dout_last`=0, `din_rdy`=1
  - both banks EMPTY, write FSM W_IDLE, all counters 0
  - memory contents are not cleared
- Reset mid-frame discards both banks' frames.
- Read latency: `request` at cycle t → `dout`/`dout_vld` at t+1 (registered synchronous RAM read).
- `dout_vld` is low in any cycle not preceded by a serviced request.
- Write acceptance is in the same cycle. A bank completing at t is readable by `request` at t+1.
- Simultaneous last write into bank A and last read of bank B in the same cycle: B becomes EMPTY and A becomes FULL at t+1. `din_rdy` stays 1 throughout.
- Back-to-back frames on the write side need no idle cycle, provided the other bank is EMPTY.
- Both banks FULL/READING with neither EMPTY: `din_rdy`=0 from the cycle after the second frame completes.

## Configuration
- `SAT_UP_ITL_ERR_EN` defined: adds outputs `ovf` and `udf`, each a 1-cycle registered pulse.
  - `ovf`: `din_vld` while `din_rdy`=0.
  - `udf`: `request` with no readable bank.
  - Also adds `bad_id`: a pulse when an invalid-geometry frame starts.
- Not defined: these ports and their logic are absent. Dropping and ignoring behaviour is unchanged.

## Structure
- Package `sat_up_itl_pkg`:
  - geometry function
  - MAX_N = MAX_ROWS·MAX_COLS
  - address width = $clog2(2·MAX_N)
  - bank-state enum
  - write-FSM enum
- Sub-module `sat_up_itl_ram`: simple dual-port RAM of 2·MAX_N × DW, one write port and one registered read port. The bank is selected by the address MSB.

## Test plan
- id 0x14, mode 1, write samples 0..95 (DW=8), then hold `request` 96 cycles → `dout` sequence 0,12,24,…,84,1,13,…,95; `dout_last` on 95; first `dout_vld` one cycle after the first `request`.
- Same frame with mode 0 → output order is the inverse permutation; interleaving and then deinterleaving through two instances restores 0..95.
- id 0x00, write 3 back-to-back 16-sample frames with no reads → `din_rdy` drops after frame 2. Frame 3 samples are dropped and `ovf` pulses (ERR_EN). Reads return frame 1, then frame 2, in order.
- Intermittent `request` (1, 0×3, 1×2, 0, 1×5) → `dout_vld` mirrors `request` delayed by 1; no samples are skipped or repeated.
- `request` before any frame completes → no `dout_vld`; `udf` pulses. id 0x3F frame → no output; `bad_id` pulses.
- `n_rst` asserted after 40 of 96 samples → all outputs 0, `din_rdy`=1; a following full frame reads out correctly.
